// File: rtl/kbd_scan_ctrl.sv
// PS/2 scancode sequencer: pops FIFO bytes, strips E0/F0 prefixes, tracks the held key,
// CapsLock and typematic repeats, and strobes registered ROM ASCII. Option: KBD_SHIFT_EN.
module kbd_scan_ctrl #(
    parameter int          CNT_W     = 8,
    parameter logic [7:0]  CAPS_CODE = 8'h58
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       data,
    input  logic             ready,
    input  logic             overflow,
    output logic             nextdata_n,
    output logic [7:0]       scan_code,
    output logic             rom_caps,
    input  logic [7:0]       ascii_in,
    output logic [7:0]       ascii_out,
    output logic             ascii_valid,
    output logic             key_down,
    output logic             capslock,
    output logic [CNT_W-1:0] key_count,
    output logic [1:0]       dbg_state_o
);

    // Handshake: a byte is taken when ready=1 is sampled in IDLE; nextdata_n is then
    // low for exactly the following cycle, and ascii_valid is a single-cycle strobe.
    typedef enum logic [1:0] {IDLE = 2'd0, POP = 2'd1, DECODE = 2'd2, LOOKUP = 2'd3} state_t;

    state_t             state_q, state_d;
    logic [7:0]         byte_q, byte_d;
    logic               nextdata_n_q, nextdata_n_d;
    logic [7:0]         scan_code_q, scan_code_d;
    logic [7:0]         ascii_q, ascii_d;
    logic               valid_q, valid_d;
    logic               key_down_q, key_down_d;
    logic               caps_q, caps_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               brk_q, brk_d;
    logic               ext_q, ext_d;
    logic [7:0]         held_q, held_d;
    logic               fresh;
`ifdef KBD_SHIFT_EN
    logic [1:0]         shift_q, shift_d;
    logic               is_shift;
    assign is_shift = (byte_q == 8'h12) || (byte_q == 8'h59);
`endif

    // A repeat of the held key is typematic; anything else is a fresh press.
    assign fresh = !(key_down_q && (byte_q == held_q));

    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        nextdata_n_d = 1'b1;
        scan_code_d  = scan_code_q;
        ascii_d      = ascii_q;
        valid_d      = 1'b0;
        key_down_d   = key_down_q;
        caps_d       = caps_q;
        count_d      = count_q;
        brk_d        = brk_q;
        ext_d        = ext_q;
        held_d       = held_q;
`ifdef KBD_SHIFT_EN
        shift_d      = shift_q;
`endif
        case (state_q)
            IDLE: begin
                if (ready) begin
                    byte_d       = data;
                    nextdata_n_d = 1'b0;
                    state_d      = POP;
                end
            end
            POP: state_d = DECODE;
            DECODE: begin
                state_d = IDLE;
                if (byte_q == 8'hE0) begin
                    ext_d = 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_d = 1'b1;
                end else if (brk_q) begin
                    if (byte_q == held_q) begin
                        key_down_d = 1'b0;
                        held_d     = 8'h00;
                    end
`ifdef KBD_SHIFT_EN
                    if (byte_q == 8'h12) shift_d[0] = 1'b0;
                    if (byte_q == 8'h59) shift_d[1] = 1'b0;
`endif
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end else if (ext_q) begin
                    held_d     = byte_q;
                    key_down_d = 1'b1;
                    if (fresh) count_d = count_q + 1'b1;
                    ext_d = 1'b0;
`ifdef KBD_SHIFT_EN
                end else if (is_shift) begin
                    if (byte_q == 8'h12) shift_d[0] = 1'b1;
                    else                 shift_d[1] = 1'b1;
`endif
                end else begin
                    held_d      = byte_q;
                    key_down_d  = 1'b1;
                    scan_code_d = byte_q;
                    if (fresh) begin
                        count_d = count_q + 1'b1;
                        if (byte_q == CAPS_CODE) caps_d = ~caps_q;
                    end
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (ascii_in != 8'h00) begin
                    ascii_d = ascii_in;
                    valid_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Overflow means bytes were lost: drop all prefix/held context, keep counters.
        if (overflow) begin
            state_d      = IDLE;
            nextdata_n_d = 1'b1;
            ascii_d      = ascii_q;
            valid_d      = 1'b0;
            key_down_d   = 1'b0;
            held_d       = 8'h00;
            brk_d        = 1'b0;
            ext_d        = 1'b0;
            caps_d       = caps_q;
            count_d      = count_q;
`ifdef KBD_SHIFT_EN
            shift_d      = 2'b00;
`endif
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= IDLE;
            byte_q       <= 8'h00;
            nextdata_n_q <= 1'b1;
            scan_code_q  <= 8'h00;
            ascii_q      <= 8'h00;
            valid_q      <= 1'b0;
            key_down_q   <= 1'b0;
            caps_q       <= 1'b0;
            count_q      <= '0;
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
            held_q       <= 8'h00;
`ifdef KBD_SHIFT_EN
            shift_q      <= 2'b00;
`endif
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            nextdata_n_q <= nextdata_n_d;
            scan_code_q  <= scan_code_d;
            ascii_q      <= ascii_d;
            valid_q      <= valid_d;
            key_down_q   <= key_down_d;
            caps_q       <= caps_d;
            count_q      <= count_d;
            brk_q        <= brk_d;
            ext_q        <= ext_d;
            held_q       <= held_d;
`ifdef KBD_SHIFT_EN
            shift_q      <= shift_d;
`endif
        end
    end

    assign nextdata_n  = nextdata_n_q;
    assign scan_code   = scan_code_q;
    assign ascii_out   = ascii_q;
    assign ascii_valid = valid_q;
    assign key_down    = key_down_q;
    assign capslock    = caps_q;
    assign key_count   = count_q;
    assign dbg_state_o = state_q;
`ifdef KBD_SHIFT_EN
    assign rom_caps    = caps_q ^ (|shift_q);
`else
    assign rom_caps    = caps_q;
`endif

endmodule
